// File: rtl/br_pred_tables_pkg.sv
// ============================================================================
// br_pred_tables_pkg : shared table geometry, counter encodings and FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package br_pred_tables_pkg;

  localparam int PTINDEXBITS   = 8;
  localparam int BTBINDEXBITS  = 4;
  localparam int BHRBITS       = 8;
  localparam int TAGBITS       = 26;
  localparam int INIT_CNT_BITS = 8;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [1:0] PT_INIT_VAL = CTR_WNT;

  typedef enum logic [0:0] {
    BP_INIT  = 1'b0,
    BP_READY = 1'b1
  } bp_state_e;

endpackage

`default_nettype wire

// File: rtl/br_pred_tables_sat_ctr2.sv
// ============================================================================
// sat_ctr2 : 2-bit saturating up/down counter step (combinational)
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_ctr2
  import br_pred_tables_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/br_pred_tables.sv
// ============================================================================
// br_pred_tables : pattern table, BTB and global history with init sweep FSM.
// Optional macro BP_STATS_EN adds saturating branch/mispredict counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module br_pred_tables #(
  parameter int PTINDEXBITS  = br_pred_tables_pkg::PTINDEXBITS,
  parameter int BTBINDEXBITS = br_pred_tables_pkg::BTBINDEXBITS,
  parameter int BHRBITS      = br_pred_tables_pkg::BHRBITS,
  parameter int TAGBITS      = br_pred_tables_pkg::TAGBITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PTINDEXBITS-1:0]  pt_rd_idx,
  input  logic [BTBINDEXBITS-1:0] btb_rd_idx,
  output logic [1:0]              rd_val_pt,
  output logic                    rd_val_btb_valid,
  output logic [TAGBITS-1:0]      rd_val_btb_tag,
  output logic [31:0]             rd_val_btb_value,
  output logic [BHRBITS-1:0]      rd_val_bhr,
  output logic                    bp_ready,
  input  logic                    upd_valid,
  input  logic                    upd_taken,
  input  logic                    upd_mispred,
  input  logic [31:0]             upd_pc,
  input  logic [31:0]             upd_target,
  input  logic [PTINDEXBITS-1:0]  upd_pt_idx,
  input  logic [BTBINDEXBITS-1:0] upd_btb_idx,
  output logic [31:0]             stat_br_cnt,
  output logic [31:0]             stat_mispred_cnt
);

  import br_pred_tables_pkg::*;

  localparam int PT_ENTRIES  = 2 ** PTINDEXBITS;
  localparam int BTB_ENTRIES = 2 ** BTBINDEXBITS;

  bp_state_e                state_q, state_d;
  logic [INIT_CNT_BITS-1:0] init_cnt_q, init_cnt_d;
  logic [BHRBITS-1:0]       bhr_q, bhr_d;

  logic [1:0]         pt_q        [PT_ENTRIES];
  logic               btb_valid_q [BTB_ENTRIES];
  logic [TAGBITS-1:0] btb_tag_q   [BTB_ENTRIES];
  logic [31:0]        btb_value_q [BTB_ENTRIES];

  logic                    pt_we;
  logic [PTINDEXBITS-1:0]  pt_waddr;
  logic [1:0]              pt_wdata;
  logic                    btb_we;
  logic                    btb_clr;
  logic [BTBINDEXBITS-1:0] btb_waddr;
  logic [1:0]              ctr_cur;
  logic [1:0]              ctr_next;
  logic                    ready;

  assign ready   = (state_q == BP_READY);
  assign ctr_cur = pt_q[upd_pt_idx];

  sat_ctr2 u_sat_ctr2 (
    .i_ctr   (ctr_cur),
    .i_taken (upd_taken),
    .o_ctr   (ctr_next)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    bhr_d      = bhr_q;
    pt_we      = 1'b0;
    pt_waddr   = upd_pt_idx;
    pt_wdata   = ctr_next;
    btb_we     = 1'b0;
    btb_clr    = 1'b0;
    btb_waddr  = upd_btb_idx;
    unique case (state_q)
      BP_INIT: begin
        // Sweep clears one PT entry per cycle; BTB valids ride along for the low indices.
        pt_we      = 1'b1;
        pt_waddr   = PTINDEXBITS'(init_cnt_q);
        pt_wdata   = PT_INIT_VAL;
        if (32'(init_cnt_q) < BTB_ENTRIES) begin
          btb_we    = 1'b1;
          btb_clr   = 1'b1;
          btb_waddr = BTBINDEXBITS'(init_cnt_q);
        end
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == {INIT_CNT_BITS{1'b1}}) state_d = BP_READY;
      end
      BP_READY: begin
        if (upd_valid) begin
          pt_we  = 1'b1;
          bhr_d  = {bhr_q[BHRBITS-2:0], upd_taken};
          btb_we = upd_taken;
        end
      end
      default: state_d = BP_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BP_INIT;
      init_cnt_q <= '0;
      bhr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      bhr_q      <= bhr_d;
    end
  end

  // Table storage is deliberately unreset; only the INIT sweep clears it.
  always_ff @(posedge clk) begin
    if (pt_we) pt_q[pt_waddr] <= pt_wdata;
    if (btb_we) begin
      btb_valid_q[btb_waddr] <= !btb_clr;
      if (!btb_clr) begin
        btb_tag_q[btb_waddr]   <= upd_pc[31 -: TAGBITS];
        btb_value_q[btb_waddr] <= upd_target;
      end
    end
  end

  assign rd_val_pt        = ready ? pt_q[pt_rd_idx] : 2'b00;
  assign rd_val_btb_valid = ready ? btb_valid_q[btb_rd_idx] : 1'b0;
  assign rd_val_btb_tag   = btb_tag_q[btb_rd_idx];
  assign rd_val_btb_value = btb_value_q[btb_rd_idx];
  assign rd_val_bhr       = bhr_q;
  assign bp_ready         = ready;

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_br_d  = stat_br_q;
    stat_mis_d = stat_mis_q;
    if (ready && upd_valid) begin
      if (stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
      if (upd_mispred && (stat_mis_q != 32'hFFFF_FFFF)) stat_mis_d = stat_mis_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_br_cnt      = stat_br_q;
  assign stat_mispred_cnt = stat_mis_q;
`else
  logic unused_mispred;
  assign unused_mispred   = upd_mispred;
  assign stat_br_cnt      = 32'd0;
  assign stat_mispred_cnt = 32'd0;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^upd_pc[31-TAGBITS:0];

endmodule

`default_nettype wire

// File: tb/tb_br_pred_tables.sv
// ============================================================================
// tb_br_pred_tables : directed self-checking bench for br_pred_tables
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_br_pred_tables;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pt_rd_idx;
  logic [3:0]  btb_rd_idx;
  logic [1:0]  rd_val_pt;
  logic        rd_val_btb_valid;
  logic [25:0] rd_val_btb_tag;
  logic [31:0] rd_val_btb_value;
  logic [7:0]  rd_val_bhr;
  logic        bp_ready;
  logic        upd_valid;
  logic        upd_taken;
  logic        upd_mispred;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [7:0]  upd_pt_idx;
  logic [3:0]  upd_btb_idx;
  logic [31:0] stat_br_cnt;
  logic [31:0] stat_mispred_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  br_pred_tables dut (
    .clk              (clk),
    .reset            (reset),
    .pt_rd_idx        (pt_rd_idx),
    .btb_rd_idx       (btb_rd_idx),
    .rd_val_pt        (rd_val_pt),
    .rd_val_btb_valid (rd_val_btb_valid),
    .rd_val_btb_tag   (rd_val_btb_tag),
    .rd_val_btb_value (rd_val_btb_value),
    .rd_val_bhr       (rd_val_bhr),
    .bp_ready         (bp_ready),
    .upd_valid        (upd_valid),
    .upd_taken        (upd_taken),
    .upd_mispred      (upd_mispred),
    .upd_pc           (upd_pc),
    .upd_target       (upd_target),
    .upd_pt_idx       (upd_pt_idx),
    .upd_btb_idx      (upd_btb_idx),
    .stat_br_cnt      (stat_br_cnt),
    .stat_mispred_cnt (stat_mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (!bp_ready && cycles < 400) begin
      tick();
      cycles++;
    end
  endtask

  int          cyc;
  logic [1:0]  exp_pt [9];
  logic [31:0] exp_br;
  logic [31:0] exp_mis;

  initial begin
    exp_pt = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
`ifdef BP_STATS_EN
    exp_br  = 32'd10;
    exp_mis = 32'd3;
`else
    exp_br  = 32'd0;
    exp_mis = 32'd0;
`endif
    reset       = 1'b0;
    pt_rd_idx   = '0;
    btb_rd_idx  = '0;
    upd_valid   = 1'b0;
    upd_taken   = 1'b0;
    upd_mispred = 1'b0;
    upd_pc      = '0;
    upd_target  = '0;
    upd_pt_idx  = '0;
    upd_btb_idx = '0;
    repeat (3) tick();

    check("rst_ready", 64'(bp_ready), 64'd0);
    check("rst_bhr", 64'(rd_val_bhr), 64'd0);
    check("rst_pt", 64'(rd_val_pt), 64'd0);
    check("rst_btbv", 64'(rd_val_btb_valid), 64'd0);
    check("rst_stat_br", 64'(stat_br_cnt), 64'd0);
    check("rst_stat_mis", 64'(stat_mispred_cnt), 64'd0);

    reset = 1'b1;
    wait_ready(cyc);
    check("init_cycles", 64'(cyc), 64'd256);

    for (int i = 0; i < 256; i++) begin
      pt_rd_idx = 8'(i);
      @(negedge clk);
      check("sweep_pt", 64'(rd_val_pt), 64'd1);
    end
    for (int i = 0; i < 16; i++) begin
      btb_rd_idx = 4'(i);
      @(negedge clk);
      check("sweep_btbv", 64'(rd_val_btb_valid), 64'd0);
    end

    // Saturating counter walk at index 0x3C
    pt_rd_idx = 8'h3C;
    for (int i = 0; i < 9; i++) begin
      upd_valid   = 1'b1;
      upd_taken   = (i < 4);
      upd_mispred = (i == 0) || (i == 4);
      upd_pt_idx  = 8'h3C;
      upd_btb_idx = 4'd0;
      tick();
      check("pt_walk", 64'(rd_val_pt), 64'(exp_pt[i]));
    end
    check("bhr_walk", 64'(rd_val_bhr), 64'hE0);

    upd_valid   = 1'b1;
    upd_taken   = 1'b1;
    upd_mispred = 1'b1;
    upd_pc      = 32'h0000_0124;
    upd_target  = 32'h0000_0200;
    upd_pt_idx  = 8'h50;
    upd_btb_idx = 4'd9;
    tick();
    upd_valid  = 1'b0;
    btb_rd_idx = 4'd9;
    #1;
    check("btb_valid", 64'(rd_val_btb_valid), 64'd1);
    check("btb_tag", 64'(rd_val_btb_tag), 64'h4);
    check("btb_value", 64'(rd_val_btb_value), 64'h200);
    check("bhr_btb", 64'(rd_val_bhr), 64'hC1);
    check("stat_br", 64'(stat_br_cnt), 64'(exp_br));
    check("stat_mis", 64'(stat_mispred_cnt), 64'(exp_mis));
    btb_rd_idx = 4'd8;
    #1;
    check("btb_other", 64'(rd_val_btb_valid), 64'd0);

    // Same-cycle read/update at pt idx 7
    pt_rd_idx   = 8'd7;
    upd_valid   = 1'b1;
    upd_taken   = 1'b1;
    upd_mispred = 1'b0;
    upd_pt_idx  = 8'd7;
    upd_btb_idx = 4'd3;
    upd_pc      = 32'h0000_1000;
    upd_target  = 32'h0000_0040;
    #1;
    check("bypass_old", 64'(rd_val_pt), 64'd1);
    tick();
    upd_valid = 1'b0;
    #1;
    check("bypass_new", 64'(rd_val_pt), 64'd2);
    check("bhr_bypass", 64'(rd_val_bhr), 64'h83);

    // Not-taken update must leave the BTB entry intact
    upd_valid   = 1'b1;
    upd_taken   = 1'b0;
    upd_pt_idx  = 8'h51;
    upd_btb_idx = 4'd9;
    upd_pc      = 32'hFFFF_FFC0;
    upd_target  = 32'h0000_DEAD;
    tick();
    upd_valid  = 1'b0;
    btb_rd_idx = 4'd9;
    #1;
    check("nt_btb_value", 64'(rd_val_btb_value), 64'h200);
    check("nt_btb_tag", 64'(rd_val_btb_tag), 64'h4);
    check("bhr_nt", 64'(rd_val_bhr), 64'h06);

    // Asynchronous reset from READY, then again mid-INIT
    reset = 1'b0;
    #1;
    check("ar_ready", 64'(bp_ready), 64'd0);
    check("ar_bhr", 64'(rd_val_bhr), 64'd0);
    check("ar_stat_br", 64'(stat_br_cnt), 64'd0);
    check("ar_stat_mis", 64'(stat_mispred_cnt), 64'd0);
    tick();
    reset       = 1'b1;
    upd_valid   = 1'b1;
    upd_taken   = 1'b1;
    upd_mispred = 1'b1;
    upd_pt_idx  = 8'h3C;
    repeat (100) tick();
    pt_rd_idx = 8'h3C;
    #1;
    check("init_rd_pt", 64'(rd_val_pt), 64'd0);
    check("init_bhr", 64'(rd_val_bhr), 64'd0);
    check("init_ready", 64'(bp_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("mid_ready", 64'(bp_ready), 64'd0);
    check("mid_bhr", 64'(rd_val_bhr), 64'd0);
    tick();
    reset = 1'b1;
    wait_ready(cyc);
    upd_valid = 1'b0;
    check("reinit_cycles", 64'(cyc), 64'd256);
    check("reinit_bhr", 64'(rd_val_bhr), 64'd0);
    check("reinit_stat_br", 64'(stat_br_cnt), 64'd0);
    #1;
    check("reinit_pt", 64'(rd_val_pt), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/br_pred_tables.md
BR_PRED_TABLES -- requirements
Module: br_pred_tables

Interface
REQ-001 Parameter PTINDEXBITS, default 8, SHALL set the pattern-table index width (256 entries).
REQ-002 Parameter BTBINDEXBITS, default 4, SHALL set the BTB index width (16 entries).
REQ-003 Parameter BHRBITS, default 8, SHALL set the global history register width.
REQ-004 Parameter TAGBITS, default 26, SHALL set the BTB tag width, with tag equal to PC[31:6].
REQ-005 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1, SHALL be the asynchronous, active-low reset.
REQ-007 Port pt_rd_idx, input, PTINDEXBITS, SHALL be the FE pattern-table read index (PC[9:2] XOR BHR).
REQ-008 Port btb_rd_idx, input, BTBINDEXBITS, SHALL be the FE BTB read index (PC[5:2]).
REQ-009 Port rd_val_pt, output, 2, SHALL be the counter at pt_rd_idx.
REQ-010 Ports rd_val_btb_valid/rd_val_btb_tag/rd_val_btb_value, output, 1/TAGBITS/32, SHALL be the BTB entry at btb_rd_idx.
REQ-011 Port rd_val_bhr, output, BHRBITS, SHALL be the current BHR.
REQ-012 Port bp_ready, output, 1, SHALL be high only in state READY; FE stalls while low.
REQ-013 Ports upd_valid/upd_taken/upd_mispred, input, 1 each, SHALL qualify an AGEX-resolved conditional branch, its outcome, and whether it was mispredicted.
REQ-014 Ports upd_pc/upd_target, input, 32 each, SHALL be the branch PC and resolved target.
REQ-015 Ports upd_pt_idx/upd_btb_idx, input, PTINDEXBITS/BTBINDEXBITS, SHALL be the indices carried down the pipe from FE.
REQ-016 Ports stat_br_cnt/stat_mispred_cnt, output, 32 each, SHALL be performance counters.

Function
REQ-017 All read outputs SHALL be combinational from pre-edge state, with no same-cycle update bypass.
REQ-018 The FSM SHALL have states INIT and READY, and INIT SHALL be entered on reset.
REQ-019 In INIT, an 8-bit init counter SHALL step 0..255, one per cycle, writing pt[cnt]=2'b01 and, for cnt<16, btb_valid[cnt]=0.
REQ-020 The FSM SHALL go INIT->READY on the edge that writes cnt=255, and READY SHALL persist until reset.
REQ-021 In INIT, rd_val_pt and rd_val_btb_valid SHALL read 0, and all upd_* inputs SHALL be ignored.
REQ-022 In READY with upd_valid=1, pt[upd_pt_idx] SHALL increment if taken or decrement if not taken, saturating at 3 and at 0.
REQ-023 In READY with upd_valid=1, the BHR SHALL shift left and insert upd_taken at bit 0.
REQ-024 In READY with upd_valid=1 and upd_taken=1, BTB[upd_btb_idx] SHALL be written with valid=1, tag=upd_pc[31:6], and value=upd_target; a not-taken update SHALL leave the BTB unchanged.
REQ-025 A read and an update to the same index in one cycle SHALL return the old value; the new value SHALL be visible the next cycle.
REQ-026 Index arithmetic SHALL truncate modulo the table size, with no out-of-range access.

Reset
REQ-027 Reset assertion at any time, including mid-INIT, SHALL immediately give BHR=0, init counter=0, state=INIT, bp_ready=0, and stat counters=0.
REQ-028 Array contents SHALL NOT be async-reset; they SHALL be cleared only by the INIT sweep.

Configuration
REQ-029 With BP_STATS_EN defined, each READY upd_valid SHALL increment stat_br_cnt, and each one with upd_mispred=1 SHALL also increment stat_mispred_cnt; both SHALL saturate at 32'hFFFFFFFF.
REQ-030 Without BP_STATS_EN, both stat outputs SHALL be constant 0 and no counter flops SHALL be synthesized.

Structure
REQ-031 PTINDEXBITS, BTBINDEXBITS, BHRBITS, TAGBITS, the 2-bit counter encodings, the PT init value 2'b01, and the FSM state encoding SHALL live in the shared define/package file used by FE and AGEX.
REQ-032 The PT counter update SHALL be one sub-module, sat_ctr2 (2-bit in, taken in, 2-bit out, combinational), instanced once.

Verification
REQ-033 The bench SHALL cover: reset release, then bp_ready low for exactly 256 cycles and high on cycle 257, after which rd_val_pt reads 1 and rd_val_btb_valid reads 0 at every index.
REQ-034 The bench SHALL cover: 4 taken updates to pt idx 0x3C, giving reads of 2, 3, 3, 3 on subsequent cycles; then 5 not-taken updates, giving reads of 2, 1, 0, 0, 0.
REQ-035 The bench SHALL cover: a taken update with upd_pc=0x0000_0124, target 0x0000_0200, and btb idx 9, so that the next cycle reads valid=1, tag=0x4, and value=0x200 at idx 9.
REQ-036 The bench SHALL cover: a same-cycle read and taken update at pt idx 7 (old value 1), so the read returns 1 that cycle and 2 the next cycle.
REQ-037 The bench SHALL cover: reset asserted at init count 100, then released, so that bp_ready returns 256 cycles later, with updates during INIT leaving BHR at 0.
REQ-038 The bench SHALL cover, with BP_STATS_EN: 10 updates of which 3 are mispredicted, giving stat_br_cnt=10 and stat_mispred_cnt=3; without the macro, both stay 0.
